// File: rtl/frame_rotator_param_pkg.sv
// Shared types and the rotation coordinate mapping for the frame rotator.
package frame_rot_pkg;

  // Per-frame rotation mode, sampled when a frame start is accepted.
  typedef enum logic [1:0] {
    ROT_NONE  = 2'd0,
    ROT_CW90  = 2'd1,
    ROT_R180  = 2'd2,
    ROT_CCW90 = 2'd3
  } rot_mode_e;

  // Output row index i for input pixel (r, c) of an n x n frame.
  function automatic int map_row(input int r, input int c, input rot_mode_e mode, input int n);
    case (mode)
      ROT_CW90:  return c;
      ROT_R180:  return n - 1 - r;
      ROT_CCW90: return n - 1 - c;
      default:   return r;
    endcase
  endfunction

  // Output column index j for input pixel (r, c) of an n x n frame.
  function automatic int map_col(input int r, input int c, input rot_mode_e mode, input int n);
    case (mode)
      ROT_CW90:  return n - 1 - r;
      ROT_R180:  return n - 1 - c;
      ROT_CCW90: return r;
      default:   return c;
    endcase
  endfunction

endpackage

// File: rtl/frame_rotator_param_if.sv
// Row-streaming bus of the frame rotator: frame start, mode and row data in,
// frame start, valid, row data and reject flag out.
interface frame_rotator_param_if #(
  parameter int N     = 16,
  parameter int PIX_W = 8
);
  import frame_rot_pkg::*;

  logic               start_i;
  rot_mode_e          mode_i;
  logic [N*PIX_W-1:0] data_i;
  logic               start_o;
  logic               vld_o;
  logic [N*PIX_W-1:0] data_o;
  logic               err_o;

  modport master (
    output start_i, mode_i, data_i,
    input  start_o, vld_o, data_o, err_o
  );

  modport slave (
    input  start_i, mode_i, data_i,
    output start_o, vld_o, data_o, err_o
  );

endinterface

// File: rtl/frame_rotator_param_bank.sv
// One N x N pixel bank. Each write scatters a full input row to its rotated
// output positions; reads return one plain output row combinationally, so a
// read in the same cycle as a write sees the old contents.
module frame_rot_bank
  import frame_rot_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int PIX_W = 8,
  localparam int AW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      wr_row_i,
  input  rot_mode_e          wr_mode_i,
  input  logic [N*PIX_W-1:0] wr_data_i,
  input  logic [AW-1:0]      rd_row_i,
  output logic [N*PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] mem_q   [N][N];
  logic [AW-1:0]    tgt_row [N];
  logic [AW-1:0]    tgt_col [N];

  // Destination coordinates of every pixel of the row being written.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      tgt_row[c] = AW'(map_row(int'(wr_row_i), c, wr_mode_i, N));
      tgt_col[c] = AW'(map_col(int'(wr_row_i), c, wr_mode_i, N));
    end
  end

  // Scatter the incoming row into its rotated positions; contents are not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int c = 0; c < N; c++) begin
        mem_q[tgt_row[c]][tgt_col[c]] <= wr_data_i[c*PIX_W +: PIX_W];
      end
    end
  end

  // Plain row read, packed with pixel 0 in the low bits.
  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < N; c++) begin
      rd_data_o[c*PIX_W +: PIX_W] = mem_q[rd_row_i][c];
    end
  end

endmodule

// File: rtl/frame_rotator_param.sv
// Ping-pong streaming frame rotator: one bank fills with the incoming frame
// (already rotated) while the other is read out row by row.
module frame_rotator_param
  import frame_rot_pkg::*;
#(
  parameter int N     = 16,
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  frame_rotator_param_if.slave  bus
);

  localparam int            AW      = $clog2(N);
  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [0:0]    WR_IDLE = 1'b0;
  localparam logic [0:0]    WR_BUSY = 1'b1;
  localparam logic [0:0]    RD_IDLE = 1'b0;
  localparam logic [0:0]    RD_BUSY = 1'b1;

  logic [0:0]         wr_state_q, wr_state_d;
  logic [AW-1:0]      wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  rot_mode_e          wr_mode_q, wr_mode_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic [0:0]         rd_state_q, rd_state_d;
  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               rd_bank_q, rd_bank_d;
  logic               wr_last;
  logic               accept;
  logic [N*PIX_W-1:0] rd_data0, rd_data1;

  assign wr_last = (wr_state_q == WR_BUSY) && (wr_cnt_q == LAST);
  assign accept  = bus.start_i && ((wr_state_q == WR_IDLE) || wr_last);

  // Next-state logic for write sequencing, start/reject pulses and readout.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    wr_mode_d  = wr_mode_q;
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    err_d      = bus.start_i && !accept;
    start_d    = wr_last;

    if (wr_state_q == WR_BUSY) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
    end
    if (wr_last) begin
      wr_bank_d  = ~wr_bank_q;
      wr_state_d = WR_IDLE;
    end
    if (accept) begin
      wr_state_d = WR_BUSY;
      wr_cnt_d   = '0;
      wr_mode_d  = bus.mode_i;
    end

    if (start_q) begin
      rd_state_d = RD_BUSY;
      rd_cnt_d   = '0;
      rd_bank_d  = ~wr_bank_q;
    end else if (rd_state_q == RD_BUSY) begin
      if (rd_cnt_q == LAST) begin
        rd_state_d = RD_IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Control registers; reset drops any partial frame and pending readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      wr_mode_q  <= ROT_NONE;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      wr_mode_q  <= wr_mode_d;
      err_q      <= err_d;
      start_q    <= start_d;
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  frame_rot_bank #(.N(N), .PIX_W(PIX_W)) u_bank0 (
    .clk       (clk),
    .we_i      ((wr_state_q == WR_BUSY) && !wr_bank_q),
    .wr_row_i  (wr_cnt_q),
    .wr_mode_i (wr_mode_q),
    .wr_data_i (bus.data_i),
    .rd_row_i  (rd_cnt_q),
    .rd_data_o (rd_data0)
  );

  frame_rot_bank #(.N(N), .PIX_W(PIX_W)) u_bank1 (
    .clk       (clk),
    .we_i      ((wr_state_q == WR_BUSY) && wr_bank_q),
    .wr_row_i  (wr_cnt_q),
    .wr_mode_i (wr_mode_q),
    .wr_data_i (bus.data_i),
    .rd_row_i  (rd_cnt_q),
    .rd_data_o (rd_data1)
  );

  assign bus.start_o = start_q;
  assign bus.err_o   = err_q;
  assign bus.vld_o   = (rd_state_q == RD_BUSY);
  assign bus.data_o  = (rd_state_q == RD_BUSY) ? (rd_bank_q ? rd_data1 : rd_data0) : '0;

endmodule

// File: tb/tb_frame_rotator_param.sv
// Self-checking bench for frame_rotator_param: a 16x16x8 instance exercised
// with table spot checks and randomized frames against a reference model,
// plus a 4x4x12 instance for the parameter sweep.
module tb_frame_rotator_param;
  import frame_rot_pkg::*;

  localparam int N   = 16;
  localparam int PW  = 8;
  localparam int W   = N * PW;
  localparam int N4  = 4;
  localparam int PW4 = 12;
  localparam int W4  = N4 * PW4;

  typedef struct {
    int mode;
    int row;
    int col;
    int exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   monOn       = 1'b0;
  int   firstStart  = 0;

  logic [PW-1:0] frm [4][N][N];
  int            frmMode [4];

  int         startOCyc[$];
  int         errCyc[$];
  int         vldCyc[$];
  logic [W-1:0] vldData[$];
  int         expStart[$];
  int         expErr[$];
  int         expVldCyc[$];
  logic [W-1:0] expVldData[$];
  int          s4Cyc[$];
  logic [W4-1:0] v4Data[$];

  frame_rotator_param_if #(.N(N),  .PIX_W(PW))  bus  ();
  frame_rotator_param_if #(.N(N4), .PIX_W(PW4)) bus4 ();

  frame_rotator_param #(.N(N),  .PIX_W(PW))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  frame_rotator_param #(.N(N4), .PIX_W(PW4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (monOn) begin
      if (bus.start_o) startOCyc.push_back(cyc);
      if (bus.err_o) errCyc.push_back(cyc);
      if (bus.vld_o) begin
        vldCyc.push_back(cyc);
        vldData.push_back(bus.data_o);
      end else begin
        checkOutput("idleDataZero", 128'(bus.data_o), '0);
      end
      if (bus4.start_o) s4Cyc.push_back(cyc);
      if (bus4.vld_o) v4Data.push_back(bus4.data_o);
    end
  end

  // Reference: which input pixel lands at output (i, j).
  function automatic void srcCoord(input int mode, input int i, input int j, input int n,
                                   output int r, output int c);
    case (mode)
      1:       begin r = n - 1 - j; c = i;         end
      2:       begin r = n - 1 - i; c = n - 1 - j; end
      3:       begin r = j;         c = n - 1 - i; end
      default: begin r = i;         c = j;         end
    endcase
  endfunction

  function automatic logic [W-1:0] packRow(input int f, input int r);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*PW +: PW] = frm[f][r][c];
    return v;
  endfunction

  task automatic addExpected(input int t, input int f);
    logic [W-1:0] row;
    int sr, sc;
    expStart.push_back(t + N + 1);
    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        srcCoord(frmMode[f], i, j, N, sr, sc);
        row[j*PW +: PW] = frm[f][sr][sc];
      end
      expVldCyc.push_back(t + N + 2 + i);
      expVldData.push_back(row);
    end
  endtask

  task automatic clearAll();
    startOCyc.delete(); errCyc.delete(); vldCyc.delete(); vldData.delete();
    expStart.delete(); expErr.delete(); expVldCyc.delete(); expVldData.delete();
  endtask

  task automatic fillRamp(input int f);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) frm[f][r][c] = PW'(r * N + c);
  endtask

  task automatic fillRandom(input int f);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) frm[f][r][c] = PW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives count frames; gap 0 means back-to-back, rejRow injects a stray start.
  task automatic applyStimulus(input int count, input int gap, input int rejRow);
    for (int f = 0; f < count; f++) begin
      if (f == 0 || gap > 0) begin
        if (f > 0) begin
          repeat (gap) begin
            bus.start_i = 1'b0;
            bus.data_i  = '0;
            @(posedge clk); #1;
          end
        end
        bus.start_i = 1'b1;
        bus.mode_i  = rot_mode_e'(2'(frmMode[f]));
        bus.data_i  = '0;
        if (f == 0) firstStart = cyc;
        addExpected(cyc, f);
        @(posedge clk); #1;
      end
      for (int r = 0; r < N; r++) begin
        bus.start_i = 1'b0;
        bus.data_i  = packRow(f, r);
        if (r == N - 1 && f < count - 1 && gap == 0) begin
          bus.start_i = 1'b1;
          bus.mode_i  = rot_mode_e'(2'(frmMode[f+1]));
          addExpected(cyc, f + 1);
        end
        if (f == 0 && r == rejRow) begin
          bus.start_i = 1'b1;
          bus.mode_i  = rot_mode_e'(2'(frmMode[0] + 1));
          expErr.push_back(cyc + 1);
        end
        @(posedge clk); #1;
      end
    end
    bus.start_i = 1'b0;
    bus.data_i  = '0;
  endtask

  task automatic checkFrames(input string tag);
    checkOutput({tag, "_startCount"}, 128'(startOCyc.size()), 128'(expStart.size()));
    for (int k = 0; k < expStart.size() && k < startOCyc.size(); k++)
      checkOutput({tag, "_startCycle"}, 128'(startOCyc[k]), 128'(expStart[k]));
    checkOutput({tag, "_errCount"}, 128'(errCyc.size()), 128'(expErr.size()));
    for (int k = 0; k < expErr.size() && k < errCyc.size(); k++)
      checkOutput({tag, "_errCycle"}, 128'(errCyc[k]), 128'(expErr[k]));
    checkOutput({tag, "_rowCount"}, 128'(vldCyc.size()), 128'(expVldCyc.size()));
    for (int k = 0; k < expVldCyc.size() && k < vldCyc.size(); k++) begin
      checkOutput($sformatf("%s_rowCycle%0d", tag, k), 128'(vldCyc[k]), 128'(expVldCyc[k]));
      checkOutput($sformatf("%s_rowData%0d", tag, k), 128'(vldData[k]), 128'(expVldData[k]));
    end
  endtask

  initial begin
    vec_t          tbl [7];
    logic [W-1:0]  rowv;
    logic [W4-1:0] row4, r4exp;
    int            t0, sr, sc, gap;

    tbl[0] = '{0, 3,  0, 'h30};
    tbl[1] = '{1, 0,  0, 'hF0};
    tbl[2] = '{1, 0, 15, 'h00};
    tbl[3] = '{1, 15, 0, 'hFF};
    tbl[4] = '{2, 0,  0, 'hFF};
    tbl[5] = '{3, 0,  0, 'h0F};
    tbl[6] = '{3, 15, 0, 'h00};

    bus.start_i  = 1'b0; bus.mode_i  = ROT_NONE; bus.data_i  = '0;
    bus4.start_i = 1'b0; bus4.mode_i = ROT_NONE; bus4.data_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetStartO", 128'(bus.start_o), '0);
    checkOutput("resetVldO",   128'(bus.vld_o),   '0);
    checkOutput("resetErrO",   128'(bus.err_o),   '0);
    checkOutput("resetDataO",  128'(bus.data_o),  '0);
    checkOutput("resetVldO4",  128'(bus4.vld_o),  '0);
    rst_n = 1'b1;
    monOn = 1'b1;
    idle(2);

    // Single ramp frames in each mode, plus table spot checks.
    for (int m = 0; m < 4; m++) begin
      clearAll();
      frmMode[0] = m;
      fillRamp(0);
      applyStimulus(1, 0, -1);
      idle(2 * N + 4);
      checkFrames($sformatf("single%0d", m));
      checkOutput("latency", 128'(startOCyc.size() > 0 ? startOCyc[0] - firstStart : -1), 128'(N + 1));
      checkOutput("vldCount", 128'(vldCyc.size()), 128'(N));
      for (int k = 0; k < 7; k++) begin
        if (tbl[k].mode == m) begin
          rowv = (vldData.size() > tbl[k].row) ? vldData[tbl[k].row] : '1;
          checkOutput($sformatf("spot_m%0d_r%0d_c%0d", m, tbl[k].row, tbl[k].col),
                      128'(rowv[tbl[k].col*PW +: PW]), 128'(tbl[k].exp));
        end
      end
    end

    // Four back-to-back frames, modes 1,2,3,0.
    clearAll();
    frmMode = '{1, 2, 3, 0};
    for (int f = 0; f < 4; f++) fillRandom(f);
    applyStimulus(4, 0, -1);
    idle(2 * N + 4);
    checkFrames("b2b");
    checkOutput("b2bContinuous",
                128'(vldCyc.size() == 4 * N ? vldCyc[4*N-1] - vldCyc[0] + 1 : 0), 128'(4 * N));

    // Randomized frame groups, alternating back-to-back and gapped.
    for (int rnd = 0; rnd < 4; rnd++) begin
      clearAll();
      for (int f = 0; f < 3; f++) begin
        frmMode[f] = int'($urandom_range(0, 3));
        fillRandom(f);
      end
      gap = (rnd % 2 == 0) ? 0 : int'($urandom_range(1, 6));
      applyStimulus(3, gap, -1);
      idle(2 * N + 4);
      checkFrames($sformatf("rand%0d", rnd));
    end

    // Stray start at write count 5 is rejected.
    clearAll();
    frmMode[0] = 2;
    fillRandom(0);
    applyStimulus(1, 0, 5);
    idle(2 * N + 4);
    checkFrames("reject");

    // Reset in the middle of the second of two back-to-back frames.
    clearAll();
    frmMode[0] = 1; frmMode[1] = 3;
    fillRandom(0); fillRandom(1);
    bus.start_i = 1'b1;
    bus.mode_i  = rot_mode_e'(2'(frmMode[0]));
    @(posedge clk); #1;
    for (int r = 0; r < N; r++) begin
      bus.start_i = (r == N - 1);
      bus.mode_i  = rot_mode_e'(2'(frmMode[1]));
      bus.data_i  = packRow(0, r);
      @(posedge clk); #1;
    end
    for (int r = 0; r < 8; r++) begin
      bus.start_i = 1'b0;
      bus.data_i  = packRow(1, r);
      @(posedge clk); #1;
    end
    checkOutput("vldBeforeReset", 128'(bus.vld_o), 128'(1));
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.data_i  = '0;
    #1;
    checkOutput("rstMidStartO", 128'(bus.start_o), '0);
    checkOutput("rstMidVldO",   128'(bus.vld_o),   '0);
    checkOutput("rstMidErrO",   128'(bus.err_o),   '0);
    checkOutput("rstMidDataO",  128'(bus.data_o),  '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearAll();
    idle(3 * N);
    checkFrames("afterReset");
    clearAll();
    frmMode[0] = 0;
    fillRandom(0);
    applyStimulus(1, 0, -1);
    idle(2 * N + 4);
    checkFrames("postReset");

    // Parameter sweep instance: 4x4, 12-bit pixels, CW90.
    s4Cyc.delete(); v4Data.delete();
    bus4.start_i = 1'b1;
    bus4.mode_i  = ROT_CW90;
    t0 = cyc;
    @(posedge clk); #1;
    for (int rr = 0; rr < N4; rr++) begin
      bus4.start_i = 1'b0;
      row4 = '0;
      for (int cc = 0; cc < N4; cc++) row4[cc*PW4 +: PW4] = PW4'(rr * N4 + cc);
      bus4.data_i = row4;
      @(posedge clk); #1;
    end
    bus4.data_i = '0;
    idle(12);
    checkOutput("n4Latency", 128'(s4Cyc.size() > 0 ? s4Cyc[0] - t0 : -1), 128'(N4 + 1));
    checkOutput("n4RowCount", 128'(v4Data.size()), 128'(N4));
    checkOutput("n4Row0", 128'(v4Data.size() > 0 ? v4Data[0] : '1), 128'(48'h00000400800C));
    for (int i = 0; i < N4; i++) begin
      r4exp = '0;
      for (int j = 0; j < N4; j++) begin
        srcCoord(1, i, j, N4, sr, sc);
        r4exp[j*PW4 +: PW4] = PW4'(sr * N4 + sc);
      end
      checkOutput($sformatf("n4Row%0d", i),
                  128'(v4Data.size() > i ? v4Data[i] : '1), 128'(r4exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
